psum_gbf_drain: RTL and testbench

Read-side controller for the double-buffered psum global buffer. While the su_adder accumulates into one bank, this block streams the finished bank word by word onto a valid/ready output toward the output/DRAM path. It zero-initialises each drained word so the bank is clean for the next swap. It drives the wrapper's `psum_gbf_r_*` and `psum_gbf_w_*_for_init` inputs and consumes its `r_data1b_out`/`r_data2b_out`.

---
 rtl/psum_gbf_drain_pkg.sv | 15 +
 rtl/psum_gbf_drain_if.sv | 26 ++
 rtl/psum_gbf_drain_fifo.sv | 57 +++++
 rtl/psum_gbf_drain.sv | 159 +++++++++++++++
 tb/tb_psum_gbf_drain.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_gbf_drain_pkg.sv
// Shared definitions for the psum global-buffer drain controller:
// the drain FSM state encoding and the output FIFO sizing.
package psum_gbf_pkg;

  localparam int DRAIN_FIFO_DEPTH = 2;
  localparam int DRAIN_FIFO_CNT_W = $clog2(DRAIN_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/psum_gbf_drain_if.sv
// Valid/ready stream carrying drained psum words (plus last marker)
// from the drain controller toward the output/DRAM path.
interface psum_gbf_drain_if #(
  parameter int DATA_BW = 512
);

  logic               out_valid;
  logic               out_ready;
  logic [DATA_BW-1:0] out_data;
  logic               out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/psum_gbf_drain_fifo.sv
// Small valid/ready FIFO holding returned bank words. The producer never
// checks for space: the drain controller only issues a read when its
// credit guarantees a free slot, so there is no input-side ready.
module drain_fifo
  import psum_gbf_pkg::*;
#(
  parameter int WIDTH = 513
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [DRAIN_FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = (DRAIN_FIFO_DEPTH > 1) ? $clog2(DRAIN_FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem [DRAIN_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign push      = in_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Storage, pointers and occupancy; everything clears so the head reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DRAIN_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + DRAIN_FIFO_CNT_W'(1);
        2'b01:   count <= count - DRAIN_FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_gbf_drain.sv
// Read-side drain controller for the double-buffered psum GBF. Streams the
// bank not being written by the su_adder onto a valid/ready port and zeroes
// each word one cycle after reading it, leaving the bank clean for the swap.
module psum_gbf_drain
  import psum_gbf_pkg::*;
#(
  parameter int PSUM_GBF_DATA_BITWIDTH = 512,
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PSUM_GBF_DEPTH         = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [PSUM_GBF_ADDR_BITWIDTH:0]   num_words,
  input  logic                              psum_gbf_w_num,
  input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data1b_out,
  input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data2b_out,
  output logic                              psum_gbf_r_en,
  output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
  output logic                              psum_gbf_w_en_for_init,
  output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
  psum_gbf_drain_if.master                  out_if,
  output logic                              busy,
  output logic                              done
);

  localparam int DW  = PSUM_GBF_DATA_BITWIDTH;
  localparam int AW  = PSUM_GBF_ADDR_BITWIDTH;
  localparam int CW  = AW + 1;
  localparam int CRW = DRAIN_FIFO_CNT_W + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(PSUM_GBF_DEPTH);

  // Requests beyond the bank size drain the whole bank rather than wrapping.
  function automatic logic [CW-1:0] sat_num_words(input logic [CW-1:0] n);
    return (n > DEPTH_CNT) ? DEPTH_CNT : n;
  endfunction

  drain_state_e                state;
  drain_state_e                state_nxt;
  logic                        sel_q;
  logic [AW-1:0]               rd_addr;
  logic [CW-1:0]               remaining;
  logic                        start_ok;
  logic                        credit_ok;
  logic                        pop;
  logic                        vld_p1;
  logic                        last_p1;
  logic [AW-1:0]               addr_p1;
  logic [DW-1:0]               rd_data_p1;
  logic [DW:0]                 head_word;
  logic [DRAIN_FIFO_CNT_W-1:0] fifo_count;

  assign start_ok = (state == ST_IDLE) && start;
  assign pop      = out_if.out_valid && out_if.out_ready;

  // A read may issue only if its word is guaranteed a FIFO slot: words held
  // plus the one already in flight must stay below capacity, counting a
  // slot freed by this cycle's pop.
  assign credit_ok = (CRW'(fifo_count) + CRW'(vld_p1)) < (CRW'(DRAIN_FIFO_DEPTH) + CRW'(pop));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and read-issue decision.
  always_comb begin
    state_nxt     = state;
    psum_gbf_r_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          psum_gbf_r_en = 1'b1;
          if (remaining == CW'(1)) begin
            state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!vld_p1 && (fifo_count == '0)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign psum_gbf_r_addr = psum_gbf_r_en ? rd_addr : '0;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);

  // Bank select, read address and words-left counter; loaded on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q     <= 1'b0;
      rd_addr   <= '0;
      remaining <= '0;
    end else if (start_ok) begin
      sel_q     <= psum_gbf_w_num;
      rd_addr   <= '0;
      remaining <= sat_num_words(num_words);
    end else if (psum_gbf_r_en) begin
      rd_addr   <= rd_addr + AW'(1);
      remaining <= remaining - CW'(1);
    end
  end

  // Stage p0 -> p1: read in flight; the same register drives the zero-write
  // of that address, keeping it one cycle behind the read on the bank port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= psum_gbf_r_en;
      last_p1 <= psum_gbf_r_en && (remaining == CW'(1));
      addr_p1 <= psum_gbf_r_addr;
    end
  end

  assign psum_gbf_w_en_for_init   = vld_p1;
  assign psum_gbf_w_addr_for_init = addr_p1;

  // The su_adder writes bank (w_num + 1); the other bank is the one drained.
  assign rd_data_p1 = sel_q ? r_data1b_out : r_data2b_out;

  // Stage p1 -> p2: returned word enters the output FIFO.
  drain_fifo #(
    .WIDTH(DW + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (vld_p1),
    .in_data  ({last_p1, rd_data_p1}),
    .out_valid(out_if.out_valid),
    .out_ready(out_if.out_ready),
    .out_data (head_word),
    .count    (fifo_count)
  );

  assign out_if.out_data = head_word[DW-1:0];
  assign out_if.out_last = head_word[DW];

endmodule

// File: tb/tb_psum_gbf_drain.sv
// Bench for psum_gbf_drain: a two-bank GBF model with registered read data,
// an expected-word queue built from bank contents at start, and a per-cycle
// compare process for output stream, read addresses and zero-writes.
module tb_psum_gbf_drain;

  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          w_num = 1'b0;
  logic [DW-1:0] r_data1b_out;
  logic [DW-1:0] r_data2b_out;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic          busy;
  logic          done;

  psum_gbf_drain_if #(.DATA_BW(DW)) out_if ();

  psum_gbf_drain #(
    .PSUM_GBF_DATA_BITWIDTH(DW),
    .PSUM_GBF_ADDR_BITWIDTH(AW),
    .PSUM_GBF_DEPTH        (DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .num_words               (num_words),
    .psum_gbf_w_num          (w_num),
    .r_data1b_out            (r_data1b_out),
    .r_data2b_out            (r_data2b_out),
    .psum_gbf_r_en           (r_en),
    .psum_gbf_r_addr         (r_addr),
    .psum_gbf_w_en_for_init  (w_en),
    .psum_gbf_w_addr_for_init(w_addr),
    .out_if                  (out_if),
    .busy                    (busy),
    .done                    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GBF bank model: registered read data, zero-write into the idle bank.
  logic [DW-1:0] bank1 [DEPTH];
  logic [DW-1:0] bank2 [DEPTH];
  always @(posedge clk) begin
    if (r_en) begin
      r_data1b_out <= bank1[r_addr];
      r_data2b_out <= bank2[r_addr];
    end
    if (w_en) begin
      if (w_num) bank1[w_addr] <= '0;
      else       bank2[w_addr] <= '0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic [DW-1:0] snap1 [DEPTH];
  logic [DW-1:0] snap2 [DEPTH];
  int            n_exp = 0;
  int            reads = 0;
  int            accepted = 0;
  int            done_cnt = 0;
  int            exp_rd_addr = 0;
  int            start_cyc = 0;
  logic          prev_r_en = 1'b0;
  logic [AW-1:0] prev_r_addr = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Per-cycle compare against the model.
  initial begin : cmp
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_r_en  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (out_if.out_valid && out_if.out_ready) begin
          accepted++;
          chk_int("word_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_vec("out_data", out_if.out_data, e[DW-1:0]);
            chk_int("out_last", int'(out_if.out_last), int'(e[DW]));
            got_data.push_back(out_if.out_data);
            got_last.push_back(out_if.out_last);
          end
        end
        if (prev_valid && !prev_ready) begin
          chk_int("stall_valid", int'(out_if.out_valid), 1);
          chk_vec("stall_data", out_if.out_data, prev_data);
          chk_int("stall_last", int'(out_if.out_last), int'(prev_last));
        end
        if (r_en) begin
          reads++;
          chk_int("read_budget", int'(reads <= n_exp), 1);
          chk_int("read_addr", int'(r_addr), exp_rd_addr);
          exp_rd_addr++;
        end
        chk_int("zero_wr_en", int'(w_en), int'(prev_r_en));
        if (prev_r_en) chk_int("zero_wr_addr", int'(w_addr), int'(prev_r_addr));
        chk_int("outstanding_le2", int'((reads - accepted) <= 2), 1);
        if (done) done_cnt++;
        prev_r_en   = r_en;
        prev_r_addr = r_addr;
        prev_valid  = out_if.out_valid;
        prev_ready  = out_if.out_ready;
        prev_data   = out_if.out_data;
        prev_last   = out_if.out_last;
      end
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      bank1[i] <= rand_word();
      bank2[i] <= rand_word();
    end
  endtask

  task automatic set_ready(input int mode, input int k);
    case (mode)
      0:       out_if.out_ready = 1'b1;
      1:       out_if.out_ready = ($urandom_range(0, 3) != 0);
      default: out_if.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
    endcase
  endtask

  task automatic check_reset_outputs();
    chk_int("rst_r_en", int'(r_en), 0);
    chk_int("rst_w_en", int'(w_en), 0);
    chk_int("rst_r_addr", int'(r_addr), 0);
    chk_int("rst_w_addr", int'(w_addr), 0);
    chk_int("rst_out_valid", int'(out_if.out_valid), 0);
    chk_int("rst_out_last", int'(out_if.out_last), 0);
    chk_vec("rst_out_data", out_if.out_data, '0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
  endtask

  // Snapshot the banks, build the expected stream and pulse start.
  task automatic begin_drain(input logic sel, input int n_req);
    int n_eff;
    @(posedge clk); #1;
    n_eff = (n_req > DEPTH) ? DEPTH : n_req;
    for (int i = 0; i < DEPTH; i++) begin
      snap1[i] = bank1[i];
      snap2[i] = bank2[i];
    end
    exp_q.delete();
    got_data.delete();
    got_last.delete();
    for (int i = 0; i < n_eff; i++)
      exp_q.push_back({(i == n_eff - 1), (sel ? bank1[i] : bank2[i])});
    n_exp       = n_eff;
    reads       = 0;
    accepted    = 0;
    done_cnt    = 0;
    exp_rd_addr = 0;
    chk_int("busy_before_start", int'(busy), 0);
    w_num     = sel;
    num_words = (AW + 1)'(n_req);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_drain(input logic sel, input int n_req, input int mode,
                           input int dup_at, output int diff);
    bit seen;
    int bad;
    logic [DW-1:0] exp_d;
    set_ready(mode, 0);
    begin_drain(sel, n_req);
    seen = 0;
    diff = -1;
    for (int k = 1; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        diff = cyc - start_cyc;
        chk_int("busy_with_done", int'(busy), 1);
      end else begin
        @(posedge clk); #1;
        set_ready(mode, k);
        if (k == dup_at) begin
          start     = 1'b1;
          num_words = (AW + 1)'(3);
        end else begin
          start = 1'b0;
        end
      end
    end
    chk_int("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("busy_after_done", int'(busy), 0);
    chk_int("done_one_cycle", int'(done), 0);
    chk_int("reads_total", reads, n_exp);
    chk_int("all_words_out", exp_q.size(), 0);
    chk_int("done_count", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = (i < n_exp) ? '0 : (sel ? snap1[i] : snap2[i]);
      if ((sel ? bank1[i] : bank2[i]) !== exp_d) bad++;
      if ((sel ? bank2[i] : bank1[i]) !== (sel ? snap2[i] : snap1[i])) bad++;
    end
    chk_int("bank_state", bad, 0);
    if (mode == 0) chk_int("done_latency", diff, (n_exp == 0) ? 1 : n_exp + 4);
  endtask

  task automatic reset_mid_drain();
    bit seen;
    int bad;
    int d;
    out_if.out_ready = 1'b1;
    fill_random();
    begin_drain(1'b0, 8);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk); #1;
      if (accepted >= 3) seen = 1;
    end
    chk_int("reached_word3", int'(seen), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    chk_int("aborted_mid_drain", int'(reads < 8), 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= reads && bank2[i] !== snap2[i]) bad++;
      if (bank1[i] !== snap1[i]) bad++;
    end
    chk_int("unread_words_intact", bad, 0);
    reset = 1'b1;
    run_drain(1'b0, 8, 0, -1, d);
    chk_int("post_reset_done_cycle", d, 12);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d;
    out_if.out_ready = 1'b1;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;

    // Directed: bank 2 holds 1..4.
    fill_random();
    for (int i = 0; i < 4; i++) bank2[i] <= DW'(i + 1);
    run_drain(1'b0, 4, 0, -1, d);
    chk_int("t1_done_cycle", d, 8);
    chk_int("t1_count", got_data.size(), 4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      chk_vec("t1_word", got_data[i], DW'(i + 1));
      chk_int("t1_last", int'(got_last[i]), int'(i == 3));
    end

    // Full bank 1.
    fill_random();
    run_drain(1'b1, 32, 0, -1, d);
    chk_int("t2_done_cycle", d, 36);

    // Backpressure 1,0,0,1.
    fill_random();
    run_drain(1'b0, 8, 2, -1, d);
    chk_int("t3_count", got_data.size(), 8);

    // Empty drain.
    run_drain(1'b1, 0, 0, -1, d);
    chk_int("t4_done_cycle", d, 1);

    // Second start while busy is ignored.
    fill_random();
    run_drain(1'b0, 10, 0, 4, d);
    chk_int("t5_done_cycle", d, 14);

    // Oversized request clamps to the bank size.
    fill_random();
    run_drain(1'b1, 50, 0, -1, d);
    chk_int("clamp_done_cycle", d, 36);
    chk_int("clamp_count", got_data.size(), 32);

    reset_mid_drain();

    for (int t = 0; t < 12; t++) begin
      fill_random();
      run_drain(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 2)), -1, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
